// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths and grant encoding for the write-back arbiter
//   WB_XLEN  : default data width
//   WB_AW    : default register address width
//   gnt_e    : which source owns the register-file write port this cycle
package wb_arbiter_pkg;

   localparam int WB_XLEN = 32;
   localparam int WB_AW   = 5;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_ALU  = 2'd1,
      GNT_LSU  = 2'd2
   } gnt_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO buffering load results ahead of write-back
//   CLK, RSTn        : clock, asynchronous active-low reset
//   push_i, din_i    : write side
//   pop_i, dout_o    : read side; dout_o shows the head entry (first-word fall-through)
//   full_o, empty_o  : occupancy flags
//   count_o          : number of stored entries
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 37
) (
   input  logic                     CLK,
   input  logic                     RSTn,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [PW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (PW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   // A push while full is still safe when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = mem_q[rptr_q];
   assign count_o = count_q;

   // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wptr_q] <= din_i;
   end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - arbitrates ALU and load results onto the register-file write port
//   CLK, RSTn                      : clock, asynchronous active-low reset
//   stall                          : pipeline stall; freezes the write port and all grants
//   alu_valid/alu_ready/rd/data    : ALU result handshake (ready is combinational, no buffer)
//   lsu_valid/lsu_ready/rd/data    : load result handshake into the load FIFO
//   wen, wadd, wdata               : registered register-file write port
//   radd1/2, fwdK_hit, fwdK_data   : bypass of the in-flight write to the read ports
//   lsu_count                      : load FIFO occupancy
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int XLEN       = WB_XLEN,
   parameter int AW         = WB_AW,
   parameter int LSU_DEPTH  = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic                         CLK,
   input  logic                         RSTn,
   input  logic                         stall,
   input  logic                         alu_valid,
   output logic                         alu_ready,
   input  logic [AW-1:0]                alu_rd,
   input  logic [XLEN-1:0]              alu_data,
   input  logic                         lsu_valid,
   output logic                         lsu_ready,
   input  logic [AW-1:0]                lsu_rd,
   input  logic [XLEN-1:0]              lsu_data,
   output logic                         wen,
   output logic [AW-1:0]                wadd,
   output logic [XLEN-1:0]              wdata,
   input  logic [AW-1:0]                radd1,
   input  logic [AW-1:0]                radd2,
   output logic                         fwd1_hit,
   output logic                         fwd2_hit,
   output logic [XLEN-1:0]              fwd1_data,
   output logic [XLEN-1:0]              fwd2_data,
   output logic [$clog2(LSU_DEPTH):0]   lsu_count
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   gnt_e             gnt;
   logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [AW+XLEN-1:0] fifo_head;
   logic [AW-1:0]    sel_rd;
   logic [XLEN-1:0]  sel_data;
   logic [SW-1:0]    starve_q, starve_d;
   logic             wen_q, wen_d;
   logic [AW-1:0]    wadd_q, wadd_d;
   logic [XLEN-1:0]  wdata_q, wdata_d;

   // Load FIFO keeps accepting during stall; only the drain side is frozen.
   assign fifo_push = lsu_valid && !fifo_full;
   assign fifo_pop  = (gnt == GNT_LSU);
   assign lsu_ready = !fifo_full;

   wb_fifo #(
      .DEPTH (LSU_DEPTH),
      .WIDTH (AW + XLEN)
   ) u_fifo (
      .CLK     (CLK),
      .RSTn    (RSTn),
      .push_i  (fifo_push),
      .din_i   ({lsu_rd, lsu_data}),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (lsu_count)
   );

   // ALU normally wins; a backlog of loads is forced through after STARVE_MAX ALU wins.
   always_comb begin
      gnt = GNT_NONE;
      if (!stall) begin
         if (starve_q == SW'(STARVE_MAX) && !fifo_empty) gnt = GNT_LSU;
         else if (alu_valid)                             gnt = GNT_ALU;
         else if (!fifo_empty)                           gnt = GNT_LSU;
      end
   end

   assign alu_ready = (gnt == GNT_ALU);

   always_comb begin
      sel_rd   = alu_rd;
      sel_data = alu_data;
      if (gnt == GNT_LSU) begin
         sel_rd   = fifo_head[AW+XLEN-1:XLEN];
         sel_data = fifo_head[XLEN-1:0];
      end

      starve_d = starve_q;
      wen_d    = wen_q;
      wadd_d   = wadd_q;
      wdata_d  = wdata_q;
      // Under stall the register file ignores writes, so the pending write is held.
      if (!stall) begin
         if (fifo_empty || gnt == GNT_LSU)
            starve_d = '0;
         else if (gnt == GNT_ALU && starve_q != SW'(STARVE_MAX))
            starve_d = starve_q + 1'b1;

         wen_d = 1'b0;
         if (gnt != GNT_NONE) begin
            // x0 results still complete their handshake but never write.
            wen_d   = (sel_rd != '0);
            wadd_d  = sel_rd;
            wdata_d = sel_data;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         starve_q <= '0;
         wen_q    <= 1'b0;
         wadd_q   <= '0;
         wdata_q  <= '0;
      end else begin
         starve_q <= starve_d;
         wen_q    <= wen_d;
         wadd_q   <= wadd_d;
         wdata_q  <= wdata_d;
      end
   end

   assign wen   = wen_q;
   assign wadd  = wadd_q;
   assign wdata = wdata_q;

   // Register-file reads return pre-write data in the write cycle, so bypass it here.
   assign fwd1_hit  = wen_q && (wadd_q == radd1) && (radd1 != '0);
   assign fwd2_hit  = wen_q && (wadd_q == radd2) && (radd2 != '0);
   assign fwd1_data = wdata_q;
   assign fwd2_data = wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic        stall, alu_valid, alu_ready, lsu_valid, lsu_ready, wen;
   logic        fwd1_hit, fwd2_hit;
   logic [4:0]  alu_rd, lsu_rd, wadd, radd1, radd2;
   logic [31:0] alu_data, lsu_data, wdata, fwd1_data, fwd2_data;
   logic [2:0]  lsu_count;

   always #5 CLK = ~CLK;

   wb_arbiter dut (
      .CLK(CLK), .RSTn(RSTn), .stall(stall),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .wen(wen), .wadd(wadd), .wdata(wdata),
      .radd1(radd1), .radd2(radd2),
      .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
      .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
      .lsu_count(lsu_count)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: queue of pending loads, starvation counter, expected write port.
   logic [36:0] m_fifo[$];
   int          m_starve;
   logic        m_wen;
   logic [4:0]  m_wadd;
   logic [31:0] m_wdata;
   bit          m_alu_acc, m_lsu_acc;
   logic        s_alu_ready, s_lsu_ready;
   logic [2:0]  s_lsu_count;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_fifo.delete();
      m_starve = 0;
      m_wen = 1'b0;
      m_wadd = '0;
      m_wdata = '0;
      m_alu_acc = 1'b0;
      m_lsu_acc = 1'b0;
   endtask

   // 0 = nobody, 1 = ALU, 2 = load queue
   function automatic int m_grant();
      if (stall) return 0;
      if (m_starve == 3 && m_fifo.size() > 0) return 2;
      if (alu_valid) return 1;
      if (m_fifo.size() > 0) return 2;
      return 0;
   endfunction

   // One clock: drive inputs on the falling edge, compare every output against the
   // model, then advance the model across the rising edge.
   task automatic step(input logic st, input logic av, input logic [4:0] ard,
                       input logic [31:0] adat, input logic lv, input logic [4:0] lrd,
                       input logic [31:0] ldat, input logic [4:0] r1, input logic [4:0] r2);
      int g;
      bit acc;
      logic [36:0] ent;
      @(negedge CLK);
      stall = st; alu_valid = av; alu_rd = ard; alu_data = adat;
      lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat; radd1 = r1; radd2 = r2;
      #1;
      g = m_grant();
      s_alu_ready = alu_ready; s_lsu_ready = lsu_ready; s_lsu_count = lsu_count;
      chk("alu_ready", alu_ready, g == 1);
      chk("lsu_ready", lsu_ready, m_fifo.size() < 4);
      chk("lsu_count", lsu_count, 32'(m_fifo.size()));
      chk("wen", wen, m_wen);
      chk("wadd", wadd, m_wadd);
      chk("wdata", wdata, m_wdata);
      chk("fwd1_hit", fwd1_hit, m_wen && m_wadd == r1 && r1 != 0);
      chk("fwd2_hit", fwd2_hit, m_wen && m_wadd == r2 && r2 != 0);
      chk("fwd1_data", fwd1_data, m_wdata);
      chk("fwd2_data", fwd2_data, m_wdata);
      @(posedge CLK);
      acc = lv && m_fifo.size() < 4;
      m_alu_acc = (g == 1);
      m_lsu_acc = acc;
      if (!st) begin
         if (g == 1) begin
            m_wen = (ard != 0); m_wadd = ard; m_wdata = adat;
         end else if (g == 2) begin
            ent = m_fifo[0];
            m_wen = (ent[36:32] != 0); m_wadd = ent[36:32]; m_wdata = ent[31:0];
         end else begin
            m_wen = 1'b0;
         end
         if (m_fifo.size() == 0 || g == 2) m_starve = 0;
         else if (g == 1 && m_starve < 3) m_starve++;
         if (g == 2) ent = m_fifo.pop_front();
      end
      if (acc) m_fifo.push_back({lrd, ldat});
   endtask

   task automatic do_reset();
      @(negedge CLK);
      #2 RSTn = 1'b0;
      #1;
      chk("rst_wen", wen, 0);
      chk("rst_count", lsu_count, 0);
      chk("rst_wadd", wadd, 0);
      chk("rst_wdata", wdata, 0);
      m_reset();
      @(negedge CLK);
      RSTn = 1'b1;
   endtask

   logic [4:0]  rd_cur, lrd_cur;
   logic        h_av;
   logic [4:0]  h_rd;
   logic [31:0] h_dat;
   logic [4:0]  exp_wadd[6];

   initial begin
      stall = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0; radd1 = 0; radd2 = 0;
      m_reset();
      do_reset();

      // ALU only
      step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      chk("alu_only_ready", s_alu_ready, 1);
      #2;
      chk("alu_only_wen", wen, 1);
      chk("alu_only_wadd", wadd, 5);
      chk("alu_only_wdata", wdata, 32'hDEADBEEF);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 chk("alu_only_wen_off", wen, 0);

      // x0 write is consumed but silent
      step(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0);
      chk("x0_ready", s_alu_ready, 1);
      #2;
      chk("x0_wen", wen, 0);
      chk("x0_fwd1", fwd1_hit, 0);

      // forwarding
      step(0, 1, 3, 32'hA5A5A5A5, 0, 0, 0, 3, 4);
      #2;
      chk("fwd_hit1", fwd1_hit, 1);
      chk("fwd_data1", fwd1_data, 32'hA5A5A5A5);
      chk("fwd_hit2", fwd2_hit, 0);

      // stall hold with loads buffered behind it
      step(0, 1, 7, 32'h7777, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 20, 32'h2020, 1, 5'(10 + k), 32'(32'h100 + k), 0, 0);
         chk("stall_ready", s_alu_ready, 0);
         #2;
         chk("stall_wen", wen, 1);
         chk("stall_wadd", wadd, 7);
      end
      step(0, 1, 20, 32'h2020, 0, 0, 0, 0, 0);
      chk("stall_count", s_lsu_count, 3);
      #2 chk("post_stall_alu", wadd, 20);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 0, 0, 0, 0, 0, 0);
         #2 chk("lsu_order", wadd, 5'(10 + k));
      end

      // starvation: rd=9 waits behind three ALU wins
      step(1, 0, 0, 0, 1, 9, 32'h99, 0, 0);
      exp_wadd = '{5'd1, 5'd2, 5'd3, 5'd9, 5'd4, 5'd5};
      rd_cur = 1;
      for (int k = 0; k < 6; k++) begin
         step(0, 1, rd_cur, 32'(rd_cur), 0, 0, 0, 0, 0);
         if (m_alu_acc) rd_cur++;
         #2 chk("starve_wadd", wadd, exp_wadd[k]);
      end

      // fill the load FIFO against continuous ALU traffic
      rd_cur = 1; lrd_cur = 16;
      for (int k = 0; k < 8; k++) begin
         step(0, 1, rd_cur, 32'(rd_cur), 1, lrd_cur, 32'(lrd_cur) << 4, 0, 0);
         if (m_alu_acc) rd_cur++;
         if (m_lsu_acc) lrd_cur++;
         if (k == 4) begin
            chk("full_count", s_lsu_count, 4);
            chk("full_ready", s_lsu_ready, 0);
            #2 chk("full_forced", wadd, 16);
         end
      end
      for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // randomized traffic with a reset in the middle of it
      h_av = 0; h_rd = 0; h_dat = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            do_reset();
            h_av = 0;
         end
         if (!h_av || m_alu_acc) begin
            h_av  = 1'($urandom_range(0, 1));
            h_rd  = 5'($urandom_range(0, 31));
            h_dat = $urandom;
         end
         step(1'($urandom_range(0, 3) == 0), h_av, h_rd, h_dat,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
